// File: rtl/graphics_controller.sv
// 2D drawing engine on a 68k-style CPU bus: register file, pixel write/read, Bresenham line
// and palette load against an 8bpp frame-buffer SRAM (two pixels per word).
module graphics_controller (
  input  logic        Clk,
  input  logic        Reset_L,
  input  logic [15:0] AddressIn,
  input  logic [15:0] DataInFromCPU,
  input  logic        AS_L,
  input  logic        UDS_L,
  input  logic        LDS_L,
  input  logic        RW,
  input  logic        GraphicsCS_L,
  input  logic        VSync_L,
  input  logic [15:0] SRam_DataIn,
  output logic [9:0]  VScrollValue,
  output logic [9:0]  HScrollValue,
  output logic [15:0] DataOutToCPU,
  output logic [17:0] Sram_AddressOut,
  output logic [15:0] Sram_DataOut,
  output logic        Sram_UDS_Out_L,
  output logic        Sram_LDS_Out_L,
  output logic        Sram_RW_Out,
  output logic [7:0]  ColourPalletteAddr,
  output logic [31:0] ColourPalletteData,
  output logic        ColourPallette_WE_H
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRPIX, S_LINE_SETUP, S_LINE_PLOT, S_RDPIX, S_RDCAP, S_PAL
  } state_t;

  state_t state_q, state_d;

  logic [15:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [15:0] colour_q, colour_d, pal_hi_q, pal_hi_d, pal_lo_q, pal_lo_d;
  logic [7:0]  pixel_rd_q, pixel_rd_d;
  logic        as_prev_q, as_prev_d;

  // Working copies latched at command start so the CPU can reload registers meanwhile.
  logic signed [11:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d, end_x_q, end_x_d, end_y_q, end_y_d;
  logic signed [11:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic        sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [7:0]  col_q, col_d;
  logic [31:0] pal_q, pal_d;

  logic        wr_en, start_ok, busy, at_end;
  logic [7:0]  reg_off, cmd;
  logic [17:0] pix_addr;
  logic signed [11:0] diff_x, diff_y, abs_x, abs_y, err_n;
  logic signed [12:0] e2, dx_ext, dy_ext;
  logic        unused_bits;

  function automatic logic [15:0] lane_wr(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic uds_l, input logic lds_l);
    logic [15:0] r;
    r = old_v;
    if (!uds_l) r[15:8] = new_v[15:8];
    if (!lds_l) r[7:0]  = new_v[7:0];
    return r;
  endfunction

  assign reg_off  = AddressIn[7:0];
  assign cmd      = DataInFromCPU[7:0];
  assign wr_en    = !GraphicsCS_L && !RW && !AS_L && as_prev_q;
  assign start_ok = wr_en && (reg_off == 8'h00) && (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign at_end   = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
  assign pix_addr = {cur_y_q[8:0], cur_x_q[9:1]};

  assign VScrollValue = 10'd0;
  assign HScrollValue = 10'd0;

  assign unused_bits = ^{AddressIn[15:8], x1_q[15:12], y1_q[15:12], x2_q[15:12], y2_q[15:12],
                         colour_q[15:8], cur_x_q[11:10], cur_y_q[11:9]};

  always_ff @(posedge Clk) begin
    if (Reset_L) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          unique case (cmd)
            8'h01:   state_d = S_WRPIX;
            8'h02:   state_d = S_LINE_SETUP;
            8'h03:   state_d = S_RDPIX;
            8'h04:   state_d = S_PAL;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LINE_SETUP: state_d = S_LINE_PLOT;
      S_LINE_PLOT:  if (at_end) state_d = S_IDLE;
      S_RDPIX:      state_d = S_RDCAP;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    diff_x = end_x_q - cur_x_q;
    diff_y = end_y_q - cur_y_q;
    abs_x  = diff_x[11] ? -diff_x : diff_x;
    abs_y  = diff_y[11] ? -diff_y : diff_y;
    e2     = {err_q, 1'b0};
    dx_ext = {dx_q[11], dx_q};
    dy_ext = {dy_q[11], dy_q};
    err_n  = err_q;
    if (e2 >= dy_ext) err_n = err_n + dy_q;
    if (e2 <= dx_ext) err_n = err_n + dx_q;
  end

  always_comb begin
    x1_d = x1_q; y1_d = y1_q; x2_d = x2_q; y2_d = y2_q;
    colour_d = colour_q; pal_hi_d = pal_hi_q; pal_lo_d = pal_lo_q;
    pixel_rd_d = pixel_rd_q;
    as_prev_d = AS_L;
    cur_x_d = cur_x_q; cur_y_d = cur_y_q; end_x_d = end_x_q; end_y_d = end_y_q;
    dx_d = dx_q; dy_d = dy_q; err_d = err_q; sx_neg_d = sx_neg_q; sy_neg_d = sy_neg_q;
    col_d = col_q; pal_d = pal_q;

    if (wr_en) begin
      unique case (reg_off)
        8'h02:   x1_d     = lane_wr(x1_q, DataInFromCPU, UDS_L, LDS_L);
        8'h04:   y1_d     = lane_wr(y1_q, DataInFromCPU, UDS_L, LDS_L);
        8'h06:   x2_d     = lane_wr(x2_q, DataInFromCPU, UDS_L, LDS_L);
        8'h08:   y2_d     = lane_wr(y2_q, DataInFromCPU, UDS_L, LDS_L);
        8'h0A:   colour_d = lane_wr(colour_q, DataInFromCPU, UDS_L, LDS_L);
        8'h0E:   pal_hi_d = lane_wr(pal_hi_q, DataInFromCPU, UDS_L, LDS_L);
        8'h10:   pal_lo_d = lane_wr(pal_lo_q, DataInFromCPU, UDS_L, LDS_L);
        default: ;
      endcase
    end

    if (start_ok) begin
      cur_x_d = x1_q[11:0];
      cur_y_d = y1_q[11:0];
      end_x_d = x2_q[11:0];
      end_y_d = y2_q[11:0];
      col_d   = colour_q[7:0];
      pal_d   = {pal_hi_q, pal_lo_q};
    end

    unique case (state_q)
      S_LINE_SETUP: begin
        dx_d     = abs_x;
        dy_d     = -abs_y;
        sx_neg_d = diff_x[11];
        sy_neg_d = diff_y[11];
        err_d    = abs_x - abs_y;
      end
      S_LINE_PLOT: begin
        if (!at_end) begin
          err_d = err_n;
          if (e2 >= dy_ext) cur_x_d = sx_neg_q ? cur_x_q - 12'sd1 : cur_x_q + 12'sd1;
          if (e2 <= dx_ext) cur_y_d = sy_neg_q ? cur_y_q - 12'sd1 : cur_y_q + 12'sd1;
        end
      end
      S_RDCAP: pixel_rd_d = cur_x_q[0] ? SRam_DataIn[7:0] : SRam_DataIn[15:8];
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset_L) begin
      x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
      colour_q <= '0; pal_hi_q <= '0; pal_lo_q <= '0;
      pixel_rd_q <= '0;
      as_prev_q <= 1'b1;
      cur_x_q <= '0; cur_y_q <= '0; end_x_q <= '0; end_y_q <= '0;
      dx_q <= '0; dy_q <= '0; err_q <= '0; sx_neg_q <= 1'b0; sy_neg_q <= 1'b0;
      col_q <= '0; pal_q <= '0;
    end else begin
      x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; y2_q <= y2_d;
      colour_q <= colour_d; pal_hi_q <= pal_hi_d; pal_lo_q <= pal_lo_d;
      pixel_rd_q <= pixel_rd_d;
      as_prev_q <= as_prev_d;
      cur_x_q <= cur_x_d; cur_y_q <= cur_y_d; end_x_q <= end_x_d; end_y_q <= end_y_d;
      dx_q <= dx_d; dy_q <= dy_d; err_q <= err_d; sx_neg_q <= sx_neg_d; sy_neg_q <= sy_neg_d;
      col_q <= col_d; pal_q <= pal_d;
    end
  end

  always_comb begin
    Sram_AddressOut     = '0;
    Sram_DataOut        = '0;
    Sram_UDS_Out_L      = 1'b1;
    Sram_LDS_Out_L      = 1'b1;
    Sram_RW_Out         = 1'b1;
    ColourPalletteAddr  = '0;
    ColourPalletteData  = '0;
    ColourPallette_WE_H = 1'b0;
    unique case (state_q)
      S_WRPIX, S_LINE_PLOT: begin
        Sram_AddressOut = pix_addr;
        Sram_DataOut    = {col_q, col_q};
        Sram_RW_Out     = 1'b0;
        Sram_UDS_Out_L  = cur_x_q[0];
        Sram_LDS_Out_L  = ~cur_x_q[0];
      end
      // Read strobes stay asserted through the capture cycle so the sampled data is stable.
      S_RDPIX, S_RDCAP: begin
        Sram_AddressOut = pix_addr;
        Sram_UDS_Out_L  = 1'b0;
        Sram_LDS_Out_L  = 1'b0;
      end
      S_PAL: begin
        ColourPalletteAddr  = col_q;
        ColourPalletteData  = pal_q;
        ColourPallette_WE_H = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    DataOutToCPU = '0;
    if (!GraphicsCS_L && RW) begin
      unique case (reg_off)
        8'h00:   DataOutToCPU = {14'b0, ~VSync_L, busy};
        8'h02:   DataOutToCPU = x1_q;
        8'h04:   DataOutToCPU = y1_q;
        8'h06:   DataOutToCPU = x2_q;
        8'h08:   DataOutToCPU = y2_q;
        8'h0A:   DataOutToCPU = colour_q;
        8'h0C:   DataOutToCPU = {8'h00, pixel_rd_q};
        8'h0E:   DataOutToCPU = pal_hi_q;
        8'h10:   DataOutToCPU = pal_lo_q;
        default: DataOutToCPU = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_graphics_controller.sv
// Self-checking bench for graphics_controller: register table, pixel table, SRAM write scoreboard
// and hand-written sequences for line, read-back, palette, held strobe and mid-command reset.
module tb_graphics_controller;
  logic        Clk = 1'b0;
  logic        Reset_L;
  logic [15:0] AddressIn, DataInFromCPU, SRam_DataIn;
  logic        AS_L, UDS_L, LDS_L, RW, GraphicsCS_L, VSync_L;
  logic [9:0]  VScrollValue, HScrollValue;
  logic [15:0] DataOutToCPU, Sram_DataOut;
  logic [17:0] Sram_AddressOut;
  logic        Sram_UDS_Out_L, Sram_LDS_Out_L, Sram_RW_Out, ColourPallette_WE_H;
  logic [7:0]  ColourPalletteAddr;
  logic [31:0] ColourPalletteData;

  graphics_controller dut (
    .Clk(Clk), .Reset_L(Reset_L), .AddressIn(AddressIn), .DataInFromCPU(DataInFromCPU),
    .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .GraphicsCS_L(GraphicsCS_L),
    .VSync_L(VSync_L), .SRam_DataIn(SRam_DataIn), .VScrollValue(VScrollValue),
    .HScrollValue(HScrollValue), .DataOutToCPU(DataOutToCPU), .Sram_AddressOut(Sram_AddressOut),
    .Sram_DataOut(Sram_DataOut), .Sram_UDS_Out_L(Sram_UDS_Out_L), .Sram_LDS_Out_L(Sram_LDS_Out_L),
    .Sram_RW_Out(Sram_RW_Out), .ColourPalletteAddr(ColourPalletteAddr),
    .ColourPalletteData(ColourPalletteData), .ColourPallette_WE_H(ColourPallette_WE_H)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];
  bit   mon_en = 1'b1;
  int   wr_cnt = 0, rd_cnt = 0, pal_cnt = 0, mark = -1;
  logic [17:0] first_addr = '0, last_addr = '0, rd_addr = '0;
  logic [7:0]  pal_addr_seen = '0;
  logic [31:0] pal_data_seen = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every SRAM write strobe must match the oldest expected write.
  always @(negedge Clk) begin
    if (Sram_RW_Out === 1'b0) begin
      if (wr_cnt == mark) first_addr = Sram_AddressOut;
      last_addr = Sram_AddressOut;
      wr_cnt++;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sram_unexpected_write addr=%h data=%h", Sram_AddressOut, Sram_DataOut);
        end else begin
          check("sram_wr", {Sram_AddressOut, Sram_UDS_Out_L, Sram_LDS_Out_L, Sram_DataOut},
                exp_q.pop_front());
        end
      end
    end
    if (Sram_RW_Out === 1'b1 && Sram_UDS_Out_L === 1'b0 && Sram_LDS_Out_L === 1'b0) begin
      rd_cnt++;
      rd_addr = Sram_AddressOut;
    end
    if (ColourPallette_WE_H === 1'b1) begin
      pal_cnt++;
      pal_addr_seen = ColourPalletteAddr;
      pal_data_seen = ColourPalletteData;
    end
  end

  function automatic logic [35:0] exp_pix(input int x, input int y, input logic [7:0] col);
    int a;
    a = (y % 512) * 512 + (x % 1024) / 2;
    return {a[17:0], (x % 2 == 1), (x % 2 == 0), col, col};
  endfunction

  task automatic push_line(input int x0, input int y0, input int x1, input int y1,
                           input logic [7:0] col);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0; y = y0;
    for (int n = 0; n < 5000; n++) begin
      exp_q.push_back(exp_pix(x, y, col));
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic bus_idle();
    AS_L = 1'b1; GraphicsCS_L = 1'b1; RW = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
  endtask

  task automatic cpu_wr(input logic [7:0] off, input logic [15:0] d, input logic uds_l,
                        input logic lds_l);
    @(posedge Clk); #1;
    AddressIn = {8'h00, off}; DataInFromCPU = d;
    GraphicsCS_L = 1'b0; RW = 1'b0; UDS_L = uds_l; LDS_L = lds_l; AS_L = 1'b0;
    @(posedge Clk); #1;
    bus_idle();
  endtask

  task automatic cpu_rd(input logic [7:0] off, output logic [15:0] d);
    @(posedge Clk); #1;
    AddressIn = {8'h00, off};
    GraphicsCS_L = 1'b0; RW = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0; AS_L = 1'b0;
    #2;
    d = DataOutToCPU;
    bus_idle();
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic [15:0] s;
    int n;
    n = 0;
    s = 16'h0001;
    while (s[0] && n < budget) begin
      cpu_rd(8'h00, s);
      n++;
    end
    if (s[0]) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout busy=%0d required=0 after %0d polls", name, s[0], n);
    end
  endtask

  typedef struct {
    logic [7:0]  off;
    logic [15:0] wdata;
    logic        uds_l, lds_l;
    logic [15:0] exp_rd;
  } reg_vec_t;

  typedef struct {
    int          x, y;
    logic [7:0]  col;
    logic        vs_l;
  } pix_vec_t;

  reg_vec_t regv[10];
  pix_vec_t pixv[4];

  initial begin
    logic [15:0] rd;
    int w0, r0, p0;

    regv[0] = '{8'h02, 16'h1234, 1'b0, 1'b0, 16'h1234};
    regv[1] = '{8'h04, 16'hABFF, 1'b0, 1'b1, 16'hAB00};
    regv[2] = '{8'h04, 16'h00CD, 1'b1, 1'b0, 16'hABCD};
    regv[3] = '{8'h06, 16'h5555, 1'b0, 1'b0, 16'h5555};
    regv[4] = '{8'h08, 16'h0F0F, 1'b0, 1'b0, 16'h0F0F};
    regv[5] = '{8'h0A, 16'h00A5, 1'b0, 1'b0, 16'h00A5};
    regv[6] = '{8'h0E, 16'h1234, 1'b0, 1'b0, 16'h1234};
    regv[7] = '{8'h10, 16'h5678, 1'b0, 1'b0, 16'h5678};
    regv[8] = '{8'h0C, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
    regv[9] = '{8'h12, 16'hFFFF, 1'b0, 1'b0, 16'h0000};

    pixv[0] = '{10,   20,  8'h5A, 1'b1};
    pixv[1] = '{11,   20,  8'hC3, 1'b0};
    pixv[2] = '{1023, 511, 8'h3C, 1'b1};
    pixv[3] = '{1024, 512, 8'h81, 1'b1};

    Reset_L = 1'b1; VSync_L = 1'b1; SRam_DataIn = 16'h0000;
    AddressIn = '0; DataInFromCPU = '0;
    bus_idle();
    repeat (3) @(posedge Clk);
    #1 Reset_L = 1'b0;

    check("rst_sram", {Sram_RW_Out, Sram_UDS_Out_L, Sram_LDS_Out_L, Sram_AddressOut, Sram_DataOut},
          {3'b111, 18'h0, 16'h0});
    check("rst_pal", {ColourPallette_WE_H, ColourPalletteAddr, ColourPalletteData}, 41'h0);
    check("rst_scroll", {VScrollValue, HScrollValue}, 20'h0);
    cpu_rd(8'h00, rd);
    check("rst_status", rd, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      cpu_wr(regv[i].off, regv[i].wdata, regv[i].uds_l, regv[i].lds_l);
      cpu_rd(regv[i].off, rd);
      check($sformatf("reg_rd_%0d", i), rd, regv[i].exp_rd);
    end

    for (int i = 0; i < 4; i++) begin
      VSync_L = pixv[i].vs_l;
      cpu_wr(8'h02, 16'(pixv[i].x), 1'b0, 1'b0);
      cpu_wr(8'h04, 16'(pixv[i].y), 1'b0, 1'b0);
      cpu_wr(8'h0A, {8'h00, pixv[i].col}, 1'b0, 1'b0);
      exp_q.push_back(exp_pix(pixv[i].x, pixv[i].y, pixv[i].col));
      cpu_wr(8'h00, 16'h0001, 1'b0, 1'b0);
      cpu_rd(8'h00, rd);
      check($sformatf("pix_status_%0d", i), rd, {14'b0, ~pixv[i].vs_l, 1'b0});
    end
    VSync_L = 1'b1;
    check("pix_sb_empty", exp_q.size(), 0);
    // Spot check of the first table entry against the hand-derived address.
    check("pix_first_addr_const", exp_pix(10, 20, 8'h5A), {18'h02805, 1'b0, 1'b1, 16'h5A5A});

    // Strobe held low for three cycles: exactly one pixel write.
    cpu_wr(8'h02, 16'd2, 1'b0, 1'b0);
    cpu_wr(8'h04, 16'd1, 1'b0, 1'b0);
    cpu_wr(8'h0A, 16'h0011, 1'b0, 1'b0);
    exp_q.push_back({18'h00201, 1'b0, 1'b1, 16'h1111});
    w0 = wr_cnt;
    @(posedge Clk); #1;
    AddressIn = 16'h0000; DataInFromCPU = 16'h0001;
    GraphicsCS_L = 1'b0; RW = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; AS_L = 1'b0;
    repeat (3) @(posedge Clk);
    #1 bus_idle();
    repeat (3) @(posedge Clk);
    check("as_held_writes", wr_cnt - w0, 1);

    // Unknown command code is a no-op.
    w0 = wr_cnt;
    cpu_wr(8'h00, 16'h0005, 1'b0, 1'b0);
    cpu_rd(8'h00, rd);
    check("nop_cmd_busy", rd, 16'h0000);
    check("nop_cmd_writes", wr_cnt - w0, 0);

    // Pixel read, odd and even x.
    SRam_DataIn = 16'hABCD;
    cpu_wr(8'h02, 16'd3, 1'b0, 1'b0);
    cpu_wr(8'h04, 16'd0, 1'b0, 1'b0);
    r0 = rd_cnt;
    cpu_wr(8'h00, 16'h0003, 1'b0, 1'b0);
    wait_idle(20, "rdpix");
    check("rdpix_strobed", (rd_cnt - r0) >= 1, 1'b1);
    check("rdpix_addr", rd_addr, 18'h00001);
    cpu_rd(8'h0C, rd);
    check("rdpix_odd", rd, 16'h00CD);
    cpu_wr(8'h02, 16'd2, 1'b0, 1'b0);
    cpu_wr(8'h00, 16'h0003, 1'b0, 1'b0);
    wait_idle(20, "rdpix2");
    cpu_rd(8'h0C, rd);
    check("rdpix_even", rd, 16'h00AB);

    // Palette load.
    cpu_wr(8'h0A, 16'h0007, 1'b0, 1'b0);
    cpu_wr(8'h0E, 16'h1234, 1'b0, 1'b0);
    cpu_wr(8'h10, 16'h5678, 1'b0, 1'b0);
    p0 = pal_cnt;
    cpu_wr(8'h00, 16'h0004, 1'b0, 1'b0);
    repeat (3) @(posedge Clk);
    check("pal_we_cycles", pal_cnt - p0, 1);
    check("pal_addr", pal_addr_seen, 8'h07);
    check("pal_data", pal_data_seen, 32'h12345678);

    // Long line; register writes and a command during busy.
    cpu_wr(8'h02, 16'd800, 1'b0, 1'b0);
    cpu_wr(8'h04, 16'd0, 1'b0, 1'b0);
    cpu_wr(8'h06, 16'd0, 1'b0, 1'b0);
    cpu_wr(8'h08, 16'd500, 1'b0, 1'b0);
    cpu_wr(8'h0A, 16'h00FF, 1'b0, 1'b0);
    push_line(800, 0, 0, 500, 8'hFF);
    w0 = wr_cnt;
    mark = wr_cnt;
    cpu_wr(8'h00, 16'h0002, 1'b0, 1'b0);
    cpu_wr(8'h02, 16'd5, 1'b0, 1'b0);
    cpu_wr(8'h00, 16'h0001, 1'b0, 1'b0);
    cpu_wr(8'h00, 16'h0002, 1'b0, 1'b0);
    wait_idle(2000, "line");
    check("line_writes", wr_cnt - w0, 801);
    check("line_first_addr", first_addr, 18'h00190);
    check("line_last_addr", last_addr, 18'h3E800);
    check("line_sb_empty", exp_q.size(), 0);
    cpu_rd(8'h02, rd);
    check("line_x1_during_busy", rd, 16'd5);
    w0 = wr_cnt;
    repeat (5) @(posedge Clk);
    check("line_no_after", wr_cnt - w0, 0);

    // Steep short line in the other octant.
    cpu_wr(8'h02, 16'd3, 1'b0, 1'b0);
    cpu_wr(8'h04, 16'd6, 1'b0, 1'b0);
    cpu_wr(8'h06, 16'd1, 1'b0, 1'b0);
    cpu_wr(8'h08, 16'd0, 1'b0, 1'b0);
    cpu_wr(8'h0A, 16'h0042, 1'b0, 1'b0);
    push_line(3, 6, 1, 0, 8'h42);
    w0 = wr_cnt;
    cpu_wr(8'h00, 16'h0002, 1'b0, 1'b0);
    wait_idle(50, "line2");
    check("line2_writes", wr_cnt - w0, 7);
    check("line2_sb_empty", exp_q.size(), 0);

    // Zero-length line.
    cpu_wr(8'h06, 16'd3, 1'b0, 1'b0);
    cpu_wr(8'h08, 16'd6, 1'b0, 1'b0);
    exp_q.push_back(exp_pix(3, 6, 8'h42));
    w0 = wr_cnt;
    cpu_wr(8'h00, 16'h0002, 1'b0, 1'b0);
    wait_idle(20, "line0");
    check("line0_writes", wr_cnt - w0, 1);

    // Reset in the middle of a line.
    mon_en = 1'b0;
    cpu_wr(8'h02, 16'd0, 1'b0, 1'b0);
    cpu_wr(8'h04, 16'd0, 1'b0, 1'b0);
    cpu_wr(8'h06, 16'd700, 1'b0, 1'b0);
    cpu_wr(8'h08, 16'd0, 1'b0, 1'b0);
    cpu_wr(8'h00, 16'h0002, 1'b0, 1'b0);
    repeat (20) @(posedge Clk);
    #1 Reset_L = 1'b1;
    @(posedge Clk); #1;
    Reset_L = 1'b0;
    check("rst_mid_strobes", {Sram_RW_Out, Sram_UDS_Out_L, Sram_LDS_Out_L}, 3'b111);
    w0 = wr_cnt;
    repeat (10) @(posedge Clk);
    check("rst_mid_no_writes", wr_cnt - w0, 0);
    cpu_rd(8'h00, rd);
    check("rst_mid_status", rd, 16'h0000);
    cpu_rd(8'h06, rd);
    check("rst_mid_regs", rd, 16'h0000);
    mon_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
